// File: rtl/cpu_obi_data_slice.sv
// Registered OBI data request slice with outstanding-transaction limiter.
// Optional response register: define CPU_OBI_SLICE_RSP_REG_EN.
package cpu_obi_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module cpu_obi_data_slice
  import cpu_obi_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  obi_req_t         core_req_i,
  output obi_resp_t        core_resp_o,
  output obi_req_t         bus_req_o,
  input  obi_resp_t        bus_resp_i,
  output logic [CNT_W-1:0] outstanding_o,
  output logic             idle_o,
  output logic             err_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  // Handshakes: a request transfers on a cycle where req && gnt are both high;
  // gnt never depends on bus-side signals, and the bus side holds its request
  // stable until the cycle where bus gnt is sampled high. Responses are
  // single-cycle rvalid pulses with no back-pressure.
  logic             valid_q;
  logic             we_q;
  logic [3:0]       be_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  logic             core_gnt;
  logic             core_rvalid;
  logic [31:0]      core_rdata;
  logic             rsp_drop;
  logic             rsp_idle;

  assign core_gnt = core_req_i.req && !valid_q && (cnt_q < MAX_CNT);

`ifdef CPU_OBI_SLICE_RSP_REG_EN
  logic             rvalid_q;
  logic [31:0]      rdata_q;
  logic [CNT_W-1:0] cnt_pend;

  // A response parked in rvalid_q is still counted in cnt_q until presented.
  assign cnt_pend    = cnt_q - CNT_W'(rvalid_q);
  assign rsp_drop    = bus_resp_i.rvalid && (cnt_pend == '0);
  assign core_rvalid = rvalid_q;
  assign core_rdata  = rdata_q;
  assign rsp_idle    = !rvalid_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= bus_resp_i.rvalid && !rsp_drop;
      if (bus_resp_i.rvalid && !rsp_drop) rdata_q <= bus_resp_i.rdata;
    end
  end
`else
  assign rsp_drop    = bus_resp_i.rvalid && (cnt_q == '0);
  assign core_rvalid = bus_resp_i.rvalid && !rsp_drop;
  assign core_rdata  = bus_resp_i.rdata;
  assign rsp_idle    = 1'b1;
`endif

  always_comb begin
    core_resp_o        = '0;
    core_resp_o.gnt    = core_gnt;
    core_resp_o.rvalid = core_rvalid;
    core_resp_o.rdata  = core_rdata;
  end

  always_comb begin
    bus_req_o = '0;
    if (valid_q) begin
      bus_req_o.req   = 1'b1;
      bus_req_o.we    = we_q;
      bus_req_o.be    = be_q;
      bus_req_o.addr  = addr_q;
      bus_req_o.wdata = wdata_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (core_gnt) begin
      valid_q <= 1'b1;
      we_q    <= core_req_i.we;
      be_q    <= core_req_i.be;
      addr_q  <= core_req_i.addr;
      wdata_q <= core_req_i.wdata;
    end else if (valid_q && bus_resp_i.gnt) begin
      valid_q <= 1'b0;
    end
  end

  // Accept and delivery in the same cycle cancel out.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (core_gnt && !core_rvalid) begin
      cnt_q <= cnt_q + ONE;
    end else if (!core_gnt && core_rvalid) begin
      cnt_q <= cnt_q - ONE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else if (rsp_drop) err_q <= 1'b1;
  end

  assign outstanding_o = cnt_q;
  assign idle_o        = !valid_q && (cnt_q == '0) && rsp_idle;
  assign err_o         = err_q;

endmodule
